core_csr_ctrl: RTL and testbench

CSR access controller for the core. It accepts single-beat register reads and writes from the pipeline over a valid/ready handshake. It owns the non-cacheable window registers (ncache_base, ncache_mask) and sequences the watchdog timer (WDT) through a 4-state FSM. It drives the WDT interrupt and the reset request to the top level.

---
 rtl/core_csr_pkg.sv | 15 +
 rtl/core_csr_ctrl_if.sv | 18 +
 rtl/core_wdt.sv | 65 ++++++
 rtl/core_csr_ctrl.sv | 77 +++++++
 tb/tb_core_csr_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/core_csr_pkg.sv
// core_csr_pkg: CSR register indices, WDT state encoding and WDT_CTRL bit positions
package core_csr_pkg;
  localparam logic [1:0] CSR_NCACHE_BASE = 2'd0;
  localparam logic [1:0] CSR_NCACHE_MASK = 2'd1;
  localparam logic [1:0] CSR_WDT_CTRL    = 2'd2;
  localparam logic [1:0] CSR_WDT_LOAD    = 2'd3;
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_IRQ_BIT = 1;
  typedef enum logic [1:0] {
    WDT_IDLE   = 2'd0,
    WDT_RUN    = 2'd1,
    WDT_WARN   = 2'd2,
    WDT_EXPIRE = 2'd3
  } wdt_state_e;
endpackage

// File: rtl/core_csr_ctrl_if.sv
// core_csr_ctrl_if: single-beat CSR request/response bus
interface core_csr_ctrl_if;
  logic        csr_req_val;
  logic        csr_req_rdy;
  logic        csr_req_we;
  logic [1:0]  csr_req_addr;
  logic [31:0] csr_req_wdata;
  logic        csr_resp_val;
  logic [31:0] csr_resp_rdata;
  modport master (
    output csr_req_val, csr_req_we, csr_req_addr, csr_req_wdata,
    input  csr_req_rdy, csr_resp_val, csr_resp_rdata
  );
  modport slave (
    input  csr_req_val, csr_req_we, csr_req_addr, csr_req_wdata,
    output csr_req_rdy, csr_resp_val, csr_resp_rdata
  );
endinterface

// File: rtl/core_wdt.sv
// core_wdt: watchdog FSM with reload counter, warning irq and expiry reset request
module core_wdt
  import core_csr_pkg::*;
#(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               kick_i,
  input  logic               irq_clr_i,
  input  logic [TIMER_W-1:0] load_i,
  output wdt_state_e         state_o,
  output logic [TIMER_W-1:0] cnt_o,
  output logic               irq_o,
  output logic               rst_req_o
);
  wdt_state_e         state_q, state_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               irq_q, irq_d, irq_set, rst_req_q;
  // Disable beats kick, kick beats expiry; EXPIRE is terminal until reset
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    irq_set = 1'b0;
    case (state_q)
      WDT_IDLE: if (en_i) begin
        state_d = WDT_RUN;
        cnt_d   = load_i;
      end
      WDT_RUN: if (!en_i) state_d = WDT_IDLE;
      else if (kick_i) cnt_d = load_i;
      else if (cnt_q == '0) begin
        state_d = WDT_WARN;
        cnt_d   = load_i;
        irq_set = 1'b1;
      end else cnt_d = cnt_q - TIMER_W'(1);
      WDT_WARN: if (!en_i) state_d = WDT_IDLE;
      else if (kick_i) begin
        state_d = WDT_RUN;
        cnt_d   = load_i;
      end else if (cnt_q == '0) state_d = WDT_EXPIRE;
      else cnt_d = cnt_q - TIMER_W'(1);
      default: ;
    endcase
    irq_d = irq_set | (irq_q & ~irq_clr_i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WDT_IDLE;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
      rst_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
      rst_req_q <= state_d == WDT_EXPIRE;
    end
  end
  assign state_o   = state_q;
  assign cnt_o     = cnt_q;
  assign irq_o     = irq_q;
  assign rst_req_o = rst_req_q;
endmodule

// File: rtl/core_csr_ctrl.sv
// core_csr_ctrl: CSR handshake, register decode, non-cacheable window and watchdog control
module core_csr_ctrl
  import core_csr_pkg::*;
#(
  parameter logic [31:0]        NCACHE_BASE_RST = 32'h8000_0000,
  parameter logic [31:0]        NCACHE_MASK_RST = 32'hF000_0000,
  parameter int                 TIMER_W         = 16,
  parameter logic [TIMER_W-1:0] WDT_LOAD_RST    = {TIMER_W{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  core_csr_ctrl_if.slave        csr,
  input  logic                  wdt_kick,
  output logic [31:0]           ncache_base,
  output logic [31:0]           ncache_mask,
  output logic                  wdt_irq,
  output logic                  wdt_rst_req
);
  logic               rdy_q, resp_val_q, en_q, en_d;
  logic [31:0]        rdata_q, rdata_d, base_q, base_d, mask_q, mask_d, rd;
  logic [TIMER_W-1:0] load_q, load_d, cnt;
  logic               acc, wr, expired, kick, irq_clr;
  wdt_state_e         wdt_state;
  assign acc     = csr.csr_req_val & rdy_q;
  assign wr      = acc & csr.csr_req_we;
  assign expired = wdt_state == WDT_EXPIRE;
  // The WDT sees the write-updated en/load so a write takes effect in its own cycle
  always_comb begin
    base_d  = (wr && csr.csr_req_addr == CSR_NCACHE_BASE) ? csr.csr_req_wdata : base_q;
    mask_d  = (wr && csr.csr_req_addr == CSR_NCACHE_MASK) ? csr.csr_req_wdata : mask_q;
    en_d    = (wr && !expired && csr.csr_req_addr == CSR_WDT_CTRL) ? csr.csr_req_wdata[CTRL_EN_BIT] : en_q;
    load_d  = (wr && !expired && csr.csr_req_addr == CSR_WDT_LOAD) ? csr.csr_req_wdata[TIMER_W-1:0] : load_q;
    kick    = wdt_kick | (wr && csr.csr_req_addr == CSR_WDT_LOAD);
    irq_clr = wr && csr.csr_req_addr == CSR_WDT_CTRL && csr.csr_req_wdata[CTRL_IRQ_BIT];
    rd      = csr.csr_req_addr == CSR_NCACHE_BASE ? base_q :
              csr.csr_req_addr == CSR_NCACHE_MASK ? mask_q :
              csr.csr_req_addr == CSR_WDT_CTRL    ? {28'd0, wdt_state, wdt_irq, en_q} :
              32'(cnt);
    rdata_d = (acc && !csr.csr_req_we) ? rd : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q      <= 1'b0;
      resp_val_q <= 1'b0;
      rdata_q    <= '0;
      base_q     <= NCACHE_BASE_RST;
      mask_q     <= NCACHE_MASK_RST;
      en_q       <= 1'b0;
      load_q     <= WDT_LOAD_RST;
    end else begin
      rdy_q      <= 1'b1;
      resp_val_q <= acc;
      rdata_q    <= rdata_d;
      base_q     <= base_d;
      mask_q     <= mask_d;
      en_q       <= en_d;
      load_q     <= load_d;
    end
  end
  core_wdt #(.TIMER_W(TIMER_W)) u_wdt (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en_d),
    .kick_i    (kick),
    .irq_clr_i (irq_clr),
    .load_i    (load_d),
    .state_o   (wdt_state),
    .cnt_o     (cnt),
    .irq_o     (wdt_irq),
    .rst_req_o (wdt_rst_req)
  );
  assign csr.csr_req_rdy    = rdy_q;
  assign csr.csr_resp_val   = resp_val_q;
  assign csr.csr_resp_rdata = rdata_q;
  assign ncache_base        = base_q;
  assign ncache_mask        = mask_q;
endmodule

// File: tb/tb_core_csr_ctrl.sv
// tb_core_csr_ctrl: directed vector table plus hand-written watchdog sequences
module tb_core_csr_ctrl;
  import core_csr_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wdt_kick = 1'b0;
  logic [31:0] ncache_base, ncache_mask;
  logic        wdt_irq, wdt_rst_req;
  int          checks = 0;
  int          failures = 0;
  core_csr_ctrl_if bus();
  core_csr_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .csr         (bus),
    .wdt_kick    (wdt_kick),
    .ncache_base (ncache_base),
    .ncache_mask (ncache_mask),
    .wdt_irq     (wdt_irq),
    .wdt_rst_req (wdt_rst_req)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd, rd, base, mask;
  } vec_t;
  vec_t v[10];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic val, input logic we, input logic [1:0] a, input logic [31:0] wd, input logic kick);
    bus.csr_req_val   = val;
    bus.csr_req_we    = we;
    bus.csr_req_addr  = a;
    bus.csr_req_wdata = wd;
    wdt_kick          = kick;
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask
  task automatic do_reset();
    drv(0, 0, 2'd0, 0, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask
  initial begin
    v[0] = '{0, CSR_WDT_CTRL,    32'h0,         32'h0,         32'h8000_0000, 32'hF000_0000};
    v[1] = '{1, CSR_NCACHE_BASE, 32'h1234_0000, 32'h0,         32'h1234_0000, 32'hF000_0000};
    v[2] = '{0, CSR_NCACHE_BASE, 32'h0,         32'h1234_0000, 32'h1234_0000, 32'hF000_0000};
    v[3] = '{1, CSR_NCACHE_MASK, 32'hFFFF_0000, 32'h0,         32'h1234_0000, 32'hFFFF_0000};
    v[4] = '{0, CSR_NCACHE_MASK, 32'h0,         32'hFFFF_0000, 32'h1234_0000, 32'hFFFF_0000};
    v[5] = '{0, CSR_WDT_LOAD,    32'h0,         32'h0,         32'h1234_0000, 32'hFFFF_0000};
    v[6] = '{1, CSR_WDT_LOAD,    32'h3,         32'h0,         32'h1234_0000, 32'hFFFF_0000};
    v[7] = '{0, CSR_WDT_LOAD,    32'h0,         32'h0,         32'h1234_0000, 32'hFFFF_0000};
    v[8] = '{1, CSR_WDT_CTRL,    32'h2,         32'h0,         32'h1234_0000, 32'hFFFF_0000};
    v[9] = '{0, CSR_WDT_CTRL,    32'h0,         32'h0,         32'h1234_0000, 32'hFFFF_0000};
    drv(0, 0, 2'd0, 0, 0);
    step();
    step();
    chk("rst_rdy", 32'(bus.csr_req_rdy), 0);
    chk("rst_resp_val", 32'(bus.csr_resp_val), 0);
    chk("rst_rdata", bus.csr_resp_rdata, 0);
    chk("rst_base", ncache_base, 32'h8000_0000);
    chk("rst_mask", ncache_mask, 32'hF000_0000);
    chk("rst_irq", 32'(wdt_irq), 0);
    chk("rst_rst_req", 32'(wdt_rst_req), 0);
    rst = 1'b0;
    chk("rdy_low_at_release", 32'(bus.csr_req_rdy), 0);
    step();
    chk("rdy_after_release", 32'(bus.csr_req_rdy), 1);
    for (int i = 0; i < 10; i++) begin
      drv(1, v[i].we, v[i].a, v[i].wd, 0);
      step();
      drv(0, 0, 2'd0, 0, 0);
      chk($sformatf("v%0d_resp_val", i), 32'(bus.csr_resp_val), 1);
      chk($sformatf("v%0d_rdata", i), bus.csr_resp_rdata, v[i].rd);
      chk($sformatf("v%0d_base", i), ncache_base, v[i].base);
      chk($sformatf("v%0d_mask", i), ncache_mask, v[i].mask);
      step();
      chk($sformatf("v%0d_resp_low", i), 32'(bus.csr_resp_val), 0);
    end
    // back-to-back write then read of the same register
    drv(1, 1, CSR_NCACHE_BASE, 32'hA5A5_0000, 0);
    step();
    chk("b2b_wr_resp", 32'(bus.csr_resp_val), 1);
    chk("b2b_base", ncache_base, 32'hA5A5_0000);
    drv(1, 0, CSR_NCACHE_BASE, 0, 0);
    step();
    chk("b2b_rd_resp", 32'(bus.csr_resp_val), 1);
    chk("b2b_rdata", bus.csr_resp_rdata, 32'hA5A5_0000);
    drv(0, 0, 2'd0, 0, 0);
    step();
    chk("b2b_resp_low", 32'(bus.csr_resp_val), 0);
    // full expiry path with LOAD=3
    drv(1, 1, CSR_WDT_LOAD, 3, 0);
    step();
    drv(1, 1, CSR_WDT_CTRL, 1, 0);
    step();
    drv(1, 0, CSR_WDT_LOAD, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("exp_irq_t%0d", k), 32'(wdt_irq), (k >= 5) ? 1 : 0);
      chk($sformatf("exp_rstreq_t%0d", k), 32'(wdt_rst_req), 0);
      step();
      chk($sformatf("exp_cnt_t%0d", k), bus.csr_resp_rdata, 32'(3 - ((k - 1) % 4)));
    end
    chk("exp_rstreq_t9", 32'(wdt_rst_req), 1);
    chk("exp_irq_t9", 32'(wdt_irq), 1);
    drv(1, 1, CSR_WDT_CTRL, 0, 0);
    step();
    drv(1, 0, CSR_WDT_CTRL, 0, 0);
    step();
    chk("exp_ctrl_en_ignored", bus.csr_resp_rdata, 32'hF);
    drv(1, 1, CSR_WDT_LOAD, 5, 1);
    step();
    drv(1, 1, CSR_WDT_CTRL, 2, 0);
    step();
    drv(1, 0, CSR_WDT_CTRL, 0, 0);
    step();
    chk("exp_w1c_ctrl", bus.csr_resp_rdata, 32'hD);
    drv(1, 0, CSR_WDT_LOAD, 0, 0);
    step();
    chk("exp_cnt_held", bus.csr_resp_rdata, 0);
    chk("exp_rstreq_held", 32'(wdt_rst_req), 1);
    do_reset();
    chk("exp_rstreq_cleared", 32'(wdt_rst_req), 0);
    chk("exp_irq_cleared", 32'(wdt_irq), 0);
    chk("exp_base_reset", ncache_base, 32'h8000_0000);
    // kick at counter 0 in RUN, then kick in WARN, then W1C
    drv(1, 1, CSR_WDT_LOAD, 3, 0);
    step();
    drv(1, 1, CSR_WDT_CTRL, 1, 0);
    step();
    for (int k = 1; k <= 8; k++) begin
      drv(1, 0, CSR_WDT_LOAD, 0, k == 4);
      chk($sformatf("kick_irq_t%0d", k), 32'(wdt_irq), 0);
      step();
      chk($sformatf("kick_cnt_t%0d", k), bus.csr_resp_rdata, 32'(3 - ((k - 1) % 4)));
    end
    chk("kick_warn_irq", 32'(wdt_irq), 1);
    drv(1, 0, CSR_WDT_CTRL, 0, 1);
    step();
    chk("kick_warn_ctrl", bus.csr_resp_rdata, 32'hB);
    drv(1, 0, CSR_WDT_CTRL, 0, 0);
    step();
    chk("kick_run_ctrl", bus.csr_resp_rdata, 32'h7);
    chk("kick_irq_stays", 32'(wdt_irq), 1);
    drv(1, 1, CSR_WDT_CTRL, 2, 0);
    step();
    drv(1, 0, CSR_WDT_CTRL, 0, 0);
    step();
    chk("w1c_ctrl", bus.csr_resp_rdata, 0);
    chk("w1c_irq", 32'(wdt_irq), 0);
    // disable in the same cycle RUN reaches counter 0
    do_reset();
    drv(1, 1, CSR_WDT_LOAD, 2, 0);
    step();
    drv(1, 1, CSR_WDT_CTRL, 1, 0);
    step();
    drv(0, 0, 2'd0, 0, 0);
    step();
    step();
    drv(1, 1, CSR_WDT_CTRL, 0, 0);
    step();
    chk("dis_irq", 32'(wdt_irq), 0);
    drv(1, 0, CSR_WDT_CTRL, 0, 0);
    step();
    chk("dis_ctrl_idle", bus.csr_resp_rdata, 0);
    chk("dis_irq2", 32'(wdt_irq), 0);
    // LOAD=0: RUN for one cycle, WARN two cycles after the en accept
    drv(1, 1, CSR_WDT_LOAD, 0, 0);
    step();
    drv(1, 1, CSR_WDT_CTRL, 1, 0);
    step();
    drv(1, 0, CSR_WDT_CTRL, 0, 0);
    step();
    chk("load0_run", bus.csr_resp_rdata, 32'h5);
    chk("load0_irq", 32'(wdt_irq), 1);
    step();
    chk("load0_warn", bus.csr_resp_rdata, 32'hB);
    // reset in the acceptance cycle drops the response
    drv(1, 0, CSR_NCACHE_BASE, 0, 0);
    rst = 1'b1;
    step();
    chk("rst_drop_resp", 32'(bus.csr_resp_val), 0);
    chk("rst_drop_irq", 32'(wdt_irq), 0);
    drv(0, 0, 2'd0, 0, 0);
    rst = 1'b0;
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
